bus_read_responder: RTL
=======================

// Module: bus_read_responder
// PURPOSE
//  Memory-side end of the 32-bit valid/ready bus read protocol driven by the fetch unit.
//  Holds a word-organised instruction/data store and answers each read request.
//  Answers come after a programmable number of wait states, as a one-cycle ready pulse with data.
//  A load port preloads or patches the store (test bench or boot loader). Sits between fetch and the memory model.
// PARAMETERS
//  DEPTH_WORDS   256        number of 32-bit words in the store (power of two, 4..65536)
//  WAIT_STATES   2          extra cycles between request capture and ready (0..15)
//  BASE_ADDRESS  32'h0      byte address of word 0
// PORTS
//  clock             input   1   rising-edge clock
//  reset             input   1   asynchronous, active-high reset
//  bus_read_vaild    input   1   read request from initiator; held high until ready is seen
//  bus_read_address  input   32  byte address; bits [1:0] ignored (word aligned)
//  bus_read_ready    output  1   one-cycle pulse: bus_read_data valid this cycle
//  bus_read_data     output  32  read word, little-endian (byte 0 in [7:0])
//  load_valid        input   1   write load_data into store this edge
//  load_address      input   32  byte address for load; bits [1:0] ignored
//  load_data         input   32  word to store
//  busy              output  1   high in any state other than IDLE
//  bus_read_error    output  1   present only with BUS_RESPONDER_ERROR_EN; see CONFIGURATION
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, bus_read_ready=0, bus_read_data=0, busy=0, error=0.
//  - Reset does not clear store contents. Reset mid-request drops it silently; no ready follows.
//  - index = (address - BASE_ADDRESS) >> 2, taken modulo DEPTH_WORDS unless the error feature is on.
//  - States:
//    IDLE    : on an edge with bus_read_vaild=1, capture address, wait counter = WAIT_STATES.
//              Go to WAIT, or to RESPOND if WAIT_STATES=0.
//    WAIT    : decrement counter each edge; at 0 go to RESPOND.
//              If vaild is low on an edge, abort to IDLE with no ready.
//    RESPOND : registered outputs ready=1 and data=store[index] for exactly one cycle, then go to RELEASE.
//    RELEASE : ready=0; hold here while vaild=1; go to IDLE on the first edge with vaild=0.
//              This stops a held-high request from being answered twice.
//  - Latency: request seen at edge N -> ready high in cycle after edge N+1+WAIT_STATES.
//    With WAIT_STATES=2 that is 3 edges after capture.
//  - Throughput: at most one response per 2+WAIT_STATES+1 cycles.
//    The initiator's one low cycle between requests satisfies RELEASE.
//  - bus_read_data holds its last value between responses; it is not cleared on drop of ready.
//  - Load port: write is committed on any edge in any state, independent of read traffic.
//  - Same-edge collision: if a load targets index on the edge that samples data for RESPOND,
//    the read returns the OLD word; the new word is visible to later reads.
//  - Address captured once in IDLE; changes on bus_read_address during WAIT are ignored.
// CONFIGURATION
//  BUS_RESPONDER_ERROR_EN defined:
//    - adds bus_read_error output.
//    - Reads with address < BASE_ADDRESS or index >= DEPTH_WORDS still complete the full handshake.
//      The RESPOND cycle carries ready=1, error=1, data=32'h0.
//    - Out-of-range loads are dropped.
//    - error is 0 in every other cycle.
//  BUS_RESPONDER_ERROR_EN undefined: no error port; out-of-range indices wrap modulo DEPTH_WORDS.
// TESTING
//  1 Preload word0=32'h33221100 via load port; hold vaild=1 with addr 0x0, WAIT_STATES=2
//    -> ready pulses once, 3 edges after capture, data=33221100; no second pulse while vaild stays high.
//  2 Fetch-style burst: preload words 0..3 = 03020100, 07060504, 0B0A0908, 0F0E0D0C.
//    Issue reads at 0x2, 0x6, 0xA, 0xE with one low cycle between
//    -> four ready pulses returning words 0..3 in order.
//  3 WAIT_STATES=0: request at edge N -> ready in cycle after edge N+1; data correct.
//  4 Abort: raise vaild for 1 cycle then drop during WAIT -> no ready; busy returns to 0; next request is served normally.
//  5 Collision: word5=AAAA5555; load word5=12345678 on the RESPOND-sampling edge of a read of 0x14
//    -> read returns AAAA5555; next read returns 12345678.
//  6 Reset asserted during WAIT -> ready=0 immediately, state IDLE, store intact (word0 still 33221100).
//    With ERROR_EN, read of 0x400 at DEPTH_WORDS=256 -> ready=1, error=1, data=0.

Source files
------------

// File: rtl/bus_read_responder_if.sv
// Read-request and load-port bundle for bus_read_responder.
// bus_read_error exists only when BUS_RESPONDER_ERROR_EN is defined.
interface bus_read_responder_if;
    logic        bus_read_vaild;
    logic [31:0] bus_read_address;
    logic        bus_read_ready;
    logic [31:0] bus_read_data;
    logic        load_valid;
    logic [31:0] load_address;
    logic [31:0] load_data;
    logic        busy;
`ifdef BUS_RESPONDER_ERROR_EN
    logic        bus_read_error;

    modport master (
        output bus_read_vaild, bus_read_address,
        output load_valid, load_address, load_data,
        input  bus_read_ready, bus_read_data, busy, bus_read_error
    );

    modport slave (
        input  bus_read_vaild, bus_read_address,
        input  load_valid, load_address, load_data,
        output bus_read_ready, bus_read_data, busy, bus_read_error
    );
`else
    modport master (
        output bus_read_vaild, bus_read_address,
        output load_valid, load_address, load_data,
        input  bus_read_ready, bus_read_data, busy
    );

    modport slave (
        input  bus_read_vaild, bus_read_address,
        input  load_valid, load_address, load_data,
        output bus_read_ready, bus_read_data, busy
    );
`endif
endinterface

// File: rtl/bus_read_responder.sv
// Memory-side read responder with programmable wait states and a load port.
// Optional macro BUS_RESPONDER_ERROR_EN: range-checks reads/loads, adds bus_read_error.
module bus_read_responder #(
    parameter int          DEPTH_WORDS  = 256,
    parameter int          WAIT_STATES  = 2,
    parameter logic [31:0] BASE_ADDRESS = 32'h0
) (
    input logic                  clock,
    input logic                  reset,
    bus_read_responder_if.slave  bus
);
    localparam int         IW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESPOND,
        S_RELEASE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic        oor_q, oor_d;
    logic        ready_q, ready_d;
    logic [31:0] data_q, data_d;

    logic [31:0] store_q [DEPTH_WORDS];

    logic [31:0]   rd_off, ld_off;
    logic [IW-1:0] rd_idx, ld_idx;
    logic          rd_oor, ld_oor;
    logic          ld_we;

    assign rd_off = bus.bus_read_address - BASE_ADDRESS;
    assign ld_off = bus.load_address - BASE_ADDRESS;
    assign rd_idx = rd_off[IW+1:2];
    assign ld_idx = ld_off[IW+1:2];

`ifdef BUS_RESPONDER_ERROR_EN
    logic error_q, error_d;
    logic unused_bits;

    // Below the base or past the last word is out of range; no wrap.
    assign rd_oor = (bus.bus_read_address < BASE_ADDRESS)
                  || (rd_off[31:IW+2] != '0);
    assign ld_oor = (bus.load_address < BASE_ADDRESS)
                  || (ld_off[31:IW+2] != '0);
    assign unused_bits = ^{rd_off[1:0], ld_off[1:0]};
    assign bus.bus_read_error = error_q;
`else
    logic unused_bits;

    // Without range checking the index simply wraps.
    assign rd_oor = 1'b0;
    assign ld_oor = 1'b0;
    assign unused_bits = ^{rd_off[31:IW+2], rd_off[1:0],
                           ld_off[31:IW+2], ld_off[1:0]};
`endif

    assign ld_we = bus.load_valid && !ld_oor;

    // Store write port: independent of read traffic, never reset.
    always_ff @(posedge clock) begin
        if (ld_we) begin
            store_q[ld_idx] <= bus.load_data;
        end
    end

    // Next-state and registered-output logic for the read handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        oor_d   = oor_q;
        ready_d = 1'b0;
        data_d  = data_q;
`ifdef BUS_RESPONDER_ERROR_EN
        error_d = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.bus_read_vaild) begin
                    idx_d   = rd_idx;
                    oor_d   = rd_oor;
                    cnt_d   = WS;
                    state_d = (WS == 4'd0) ? S_RESPOND : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.bus_read_vaild) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_RESPOND;
                    end
                end
            end
            S_RESPOND: begin
                // The store read sees the pre-edge word, so a same-edge load
                // to this index is not returned by this response.
                ready_d = 1'b1;
                data_d  = oor_q ? 32'h0 : store_q[idx_q];
`ifdef BUS_RESPONDER_ERROR_EN
                error_d = oor_q;
`endif
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!bus.bus_read_vaild) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= 32'h0;
`ifdef BUS_RESPONDER_ERROR_EN
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            oor_q   <= oor_d;
            ready_q <= ready_d;
            data_q  <= data_d;
`ifdef BUS_RESPONDER_ERROR_EN
            error_q <= error_d;
`endif
        end
    end

    assign bus.bus_read_ready = ready_q;
    assign bus.bus_read_data  = data_q;
    assign bus.busy           = (state_q != S_IDLE);
endmodule
